// File: rtl/mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-slave signals around the memory arbiter.
// The arbiter connects through "master" (it masters the shared memory port);
// the surrounding core and memory connect through "slave".
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned MW = 8
);
    logic          ifu_req_valid;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_rdata;

    logic          lsu_req_valid;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr;
    logic          lsu_wen;
    logic [DW-1:0] lsu_wdata;
    logic [MW-1:0] lsu_wmask;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_rdata;

    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] s_addr;
    logic          s_wen;
    logic [DW-1:0] s_wdata;
    logic [MW-1:0] s_wmask;
    logic          s_rvalid;
    logic [DW-1:0] s_rdata;

    modport master (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  s_ready, s_rvalid, s_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output s_valid, s_addr, s_wen, s_wdata, s_wmask
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output s_ready, s_rvalid, s_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  s_valid, s_addr, s_wen, s_wdata, s_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between the
// instruction fetch unit (master 0) and the load/store unit (master 1).
// One transaction in flight; a watchdog aborts stuck transactions.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MW      = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus,
    output logic          busy,
    output logic          timeout_err
);
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [MW-1:0] wmask_q, wmask_d;
    logic [CW-1:0] wdog_q, wdog_d;
    logic          terr_q, terr_d;

    logic          any_req;
    logic          winner;
    logic          limit;
    logic          resp;
    logic [DW-1:0] resp_data;

    // Pick the winner among pending requests; ties go to the master not served last.
    always_comb begin
        any_req = bus.ifu_req_valid | bus.lsu_req_valid;
        if (bus.ifu_req_valid && bus.lsu_req_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = bus.lsu_req_valid;
        end
    end

    // Next-state, latching and handshake outputs.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        wdog_d       = wdog_q;
        terr_d       = terr_q;
        resp         = 1'b0;
        resp_data    = '0;
        bus.ifu_req_ready  = 1'b0;
        bus.lsu_req_ready  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.ifu_rdata      = '0;
        bus.lsu_resp_valid = 1'b0;
        bus.lsu_rdata      = '0;
        bus.s_valid        = 1'b0;
        limit = (wdog_q == CW'(TIMEOUT - 1));

        unique case (state_q)
            StIdle: begin
                // Ready is gated by rst so nothing is accepted while held in reset.
                if (any_req && rst) begin
                    if (winner) begin
                        bus.lsu_req_ready = 1'b1;
                        addr_d  = bus.lsu_addr;
                        wen_d   = bus.lsu_wen;
                        wdata_d = bus.lsu_wdata;
                        wmask_d = bus.lsu_wmask;
                    end else begin
                        bus.ifu_req_ready = 1'b1;
                        addr_d  = bus.ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                    grant_d      = winner;
                    last_grant_d = winner;
                    wdog_d       = '0;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                wdog_d = wdog_q + CW'(1);
                if (limit) begin
                    resp    = 1'b1;
                    terr_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    bus.s_valid = 1'b1;
                    if (bus.s_ready) state_d = StWait;
                end
            end
            StWait: begin
                wdog_d = wdog_q + CW'(1);
                // A response on the limit cycle is a normal completion.
                if (bus.s_rvalid) begin
                    resp      = 1'b1;
                    resp_data = bus.s_rdata;
                    state_d   = StIdle;
                end else if (limit) begin
                    resp    = 1'b1;
                    terr_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (resp) begin
            if (grant_q) begin
                bus.lsu_resp_valid = 1'b1;
                bus.lsu_rdata      = resp_data;
            end else begin
                bus.ifu_resp_valid = 1'b1;
                bus.ifu_rdata      = resp_data;
            end
        end
    end

    // State registers; last_grant resets to LSU so IFU wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            wdog_q       <= '0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            wdog_q       <= wdog_d;
            terr_q       <= terr_d;
        end
    end

    // Registered request fields and status straight to the outputs.
    always_comb begin
        bus.s_addr  = addr_q;
        bus.s_wen   = wen_q;
        bus.s_wdata = wdata_q;
        bus.s_wmask = wmask_q;
        busy        = (state_q != StIdle);
        timeout_err = terr_q;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single data-memory port between instruction fetch (IFU, master 0) and load/store (LSU, master 1).
- Lets the core move off its combinational fetch and a second read path to one shared, variable-latency memory interface.
- Accepts one transaction at a time with round-robin fairness.
- Sequences request and response handshakes to the memory slave, with a watchdog timeout.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MW, 8, write-mask width (one bit per byte lane; upper bits unused for DW=32)
- TIMEOUT, 1024, cycles allowed in ISSUE+WAIT before forced abort (minimum 4)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU request pending; held until accepted
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  AW  IFU read address
- ifu_resp_valid  out  1  one-cycle pulse, IFU response
- ifu_rdata  out  DW  IFU read data, valid with ifu_resp_valid
- lsu_req_valid  in  1  LSU request pending; held until accepted
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  AW  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DW  write data
- lsu_wmask  in  MW  byte-lane write mask
- lsu_resp_valid  out  1  one-cycle pulse, LSU response/ack
- lsu_rdata  out  DW  LSU read data
- s_valid  out  1  request to memory slave
- s_ready  in  1  slave accepts request
- s_addr  out  AW  latched address
- s_wen  out  1  latched write enable (0 for IFU)
- s_wdata  out  DW  latched write data (0 for IFU)
- s_wmask  out  MW  latched mask (0 for IFU)
- s_rvalid  in  1  slave response/ack
- s_rdata  in  DW  slave read data
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky; set on watchdog abort

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; grant=0; last_grant=1 (LSU), so IFU wins the first tie; watchdog counter=0. All outputs 0, including s_* and timeout_err.
- Reset mid-transaction drops the transaction with no response. The slave is reset by the same rst.
- States: IDLE, ISSUE, WAIT.
- IDLE, one request valid: that master wins.
- IDLE, both requests valid: the master not equal to last_grant wins.
- IDLE, acceptance: combinationally assert the winner's req_ready in that cycle. Latch addr/wen/wdata/wmask; IFU latches wen=0, wdata=0, wmask=0. Set grant and last_grant to the winner. Go to ISSUE.
- ISSUE: s_valid=1 with latched fields, held stable. When s_ready=1, go to WAIT next cycle.
- WAIT: s_valid=0. When s_rvalid=1, pulse the granted master's resp_valid in the same cycle, with rdata = s_rdata passed through combinationally. Go to IDLE.
- The non-granted resp_valid is always 0. The non-granted rdata and all rdata outside a response are 0.
- s_rvalid is ignored in IDLE and ISSUE. The slave must not respond in the same cycle as the s_valid/s_ready handshake.
- req_ready is 0 in ISSUE and WAIT. There is no new accept in the same cycle as a response; the earliest next accept is the cycle after returning to IDLE.
- Latency: accept at cycle 0, s_valid from cycle 1. With s_ready=1 at cycle 1 and s_rvalid at cycle 2, resp_valid occurs at cycle 2. The minimum accept-to-response is 2 cycles; back-to-back throughput is 1 transaction per 3 cycles.
- Watchdog: the counter clears on entering ISSUE and increments each cycle in ISSUE or WAIT. At count == TIMEOUT-1 with no completion that cycle:
  - force state to IDLE
  - pulse the granted resp_valid with rdata=0
  - drop s_valid
  - set timeout_err=1, which stays set until reset
- A completion in the same cycle as the watchdog limit counts as normal completion; timeout_err is not set.
- Masters must hold req_valid and fields stable until req_ready. The arbiter does not check for withdrawal.

Test Plan:
- Reset with rst=0 while inputs toggle -> all outputs 0, busy=0; release -> IDLE.
- IFU only, addr=0x80000000, slave ready=1, rvalid next cycle with rdata=0x00100073 -> ifu_req_ready at cycle 0, s_addr=0x80000000 with s_wen=0 at cycle 1, ifu_resp_valid=1 with ifu_rdata=0x00100073 at cycle 2, lsu_resp_valid=0.
- Both valid from reset, repeated -> grants IFU, LSU, IFU, LSU in order; each resp goes only to its own master.
- LSU write, addr=0x80001000, wdata=0xA5A5A5A5, wmask=0x0F, slave ready delayed 3 cycles -> s_valid held 4 cycles with stable fields, then lsu_resp_valid pulse after s_rvalid.
- TIMEOUT=8, slave never responds -> after 8 cycles in ISSUE+WAIT: resp_valid with rdata=0, timeout_err=1 sticky, next request still served.
- Assert rst=0 during WAIT -> immediate IDLE, no resp_valid; a late s_rvalid after release is ignored.
